// File: rtl/nios2_dbg_ocimem_ctrl.sv
// OCI debug memory controller: applies JTAG debug-slave commands to the OCI RAM and the monitor registers,
// and gives the CPU an Avalon-MM slave port into the same RAM. JTAG commands always take priority.
module nios2_dbg_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JRD1 = 3'd1,
    JRD2 = 3'd2,
    CRD1 = 3'd3,
    CRD2 = 3'd4
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   mon_a_reg;
  logic [DATA_W-1:0]   ram_q;

  logic                any_strb;
  logic                multi_strb;
  logic                is_idle;
  logic                jtag_wr;
  logic                cpu_wr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [LANES-1:0]    wr_be;
  logic [ADDR_W-1:0]   rd_addr;
  logic                unused_jdo;

  assign unused_jdo   = ^{jdo[37:36], jdo[1:0]};
  assign avs_readdata = ram_q;

  // Strobe decode and the single RAM port's address/data steering
  always_comb begin
    any_strb   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    multi_strb = (take_action_ocimem_a & take_action_ocimem_b)
               | (take_action_ocimem_a & take_no_action_ocimem_a)
               | (take_action_ocimem_b & take_no_action_ocimem_a);
    is_idle    = (state == IDLE);
    jtag_wr    = is_idle & take_action_ocimem_b;
    cpu_wr     = is_idle & ~any_strb & avs_write;
    wr_addr    = jtag_wr ? mon_a_reg : avs_address;
    wr_data    = jtag_wr ? jdo[34:3] : avs_writedata;
    wr_be      = jtag_wr ? {LANES{1'b1}} : avs_byteenable;
    rd_addr    = (state == JRD1) ? mon_a_reg : avs_address;
  end

  // CPU may only complete a write in IDLE with no strobe, or a read in CRD2
  always_comb begin
    avs_waitrequest = 1'b1;
    if (reset_n) begin
      case (state)
        IDLE:    avs_waitrequest = any_strb | (avs_read & ~avs_write);
        CRD2:    avs_waitrequest = 1'b0;
        default: avs_waitrequest = 1'b1;
      endcase
    end
  end

  // RAM array: byte-lane writes, contents survive reset
  always_ff @(posedge clk) begin
    if (jtag_wr | cpu_wr) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control FSM, monitor registers and registered RAM output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      ram_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            mon_a_reg <= mon_a_reg + ADDR_W'(1);
            if (multi_strb) monitor_error <= 1'b1;
          end else if (take_action_ocimem_a) begin
            mon_a_reg     <= jdo[ADDR_W+1:2];
            monitor_ready <= 1'b0;
            if (jdo[34]) monitor_error <= 1'b0;
            if (take_no_action_ocimem_a) monitor_error <= 1'b1;
            if (jdo[35]) state <= JRD1;
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            state         <= JRD1;
          end else if (avs_read & ~avs_write) begin
            state <= CRD1;
          end
        end
        JRD1: begin
          ram_q <= mem[rd_addr];
          state <= JRD2;
        end
        // Every JTAG read post-increments so read-next streams onward from the loaded address
        JRD2: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          mon_a_reg     <= mon_a_reg + ADDR_W'(1);
          state         <= IDLE;
        end
        CRD1: begin
          ram_q <= mem[rd_addr];
          state <= CRD2;
        end
        CRD2:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!is_idle && any_strb) monitor_error <= 1'b1;
    end
  end

endmodule
